// File: rtl/shifter_seq.sv
// Multi-cycle operand shifter: SLL/SRL/SRA/ROR, up to STEP bits per clock,
// with valid/ready handshakes on the request and result sides.
module shifter_seq #(
    parameter int WIDTH = 32,
    parameter int STEP  = 1,
    localparam int AMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             fun,
    input  logic [3:0]       op,
    input  logic [1:0]       shift_type,
    input  logic [AMT_W-1:0] shift_amount,
    input  logic [WIDTH-1:0] rd2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] data,
    output logic             busy,
    output logic [1:0]       state_dbg
);

    // Handshake: a request transfers on a rising edge with in_valid && in_ready,
    // a result transfers with out_valid && out_ready; ready/valid depend on state only.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [AMT_W-1:0] STEP_A = AMT_W'(STEP);
    localparam logic [3:0]       OP_SHIFT = 4'b1101;

    state_t           state, state_n;
    logic [WIDTH-1:0] acc, acc_n;
    logic [AMT_W-1:0] rem, rem_n;
    logic [1:0]       typ, typ_n;
    logic [WIDTH-1:0] data_q, data_n;
    logic [AMT_W-1:0] k;
    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] rot;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            acc    <= '0;
            rem    <= '0;
            typ    <= '0;
            data_q <= '0;
        end else begin
            state  <= state_n;
            acc    <= acc_n;
            rem    <= rem_n;
            typ    <= typ_n;
            data_q <= data_n;
        end
    end

    // One step of the datapath: shift the accumulator by min(STEP, rem).
    always_comb begin
        k       = (rem > STEP_A) ? STEP_A : rem;
        rot     = acc;
        shifted = acc;
        for (int i = 0; i < STEP; i++) begin
            if (i < int'(k)) begin
                rot = {rot[0], rot[WIDTH-1:1]};
            end
        end
        case (typ)
            2'b00:   shifted = acc << k;
            2'b01:   shifted = acc >> k;
            2'b10:   shifted = $signed(acc) >>> k;
            default: shifted = rot;
        endcase
    end

    always_comb begin
        state_n = state;
        acc_n   = acc;
        rem_n   = rem;
        typ_n   = typ;
        data_n  = data_q;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    acc_n = rd2;
                    rem_n = shift_amount;
                    typ_n = shift_type;
                    if (op != OP_SHIFT || fun || shift_amount == '0) begin
                        state_n = DONE;
                        data_n  = rd2;
                    end else begin
                        state_n = SHIFT;
                    end
                end
            end
            SHIFT: begin
                acc_n = shifted;
                rem_n = rem - k;
                if (rem == k) begin
                    state_n = DONE;
                    data_n  = shifted;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign data      = data_q;
    assign state_dbg = state;

endmodule

// File: doc/shifter_seq.md
Name: shifter_seq

Overview:
- Parametrised, multi-cycle successor to the datapath shifter.
- Shifts a WIDTH-bit operand by up to STEP bit positions per clock, with a valid/ready handshake on both input and output.
- Supports SLL, SRL, SRA and a new rotate-right mode (ROR).
- Keeps the existing decode gating: it shifts only when op = 4'b1101 and fun = 0; every other instruction passes the operand through unchanged.
- Sits between the register-file read port (rd2) and the writeback mux, and stalls the pipeline through in_ready/out_valid.

Parameters:
- WIDTH, 32, operand/result width in bits. Must be a power of two, ≥ 4.
- STEP, 1, maximum bit positions shifted per cycle. Power of two, 1 ≤ STEP ≤ WIDTH/2.
- AMT_W, $clog2(WIDTH), width of shift_amount. Derived localparam; do not override.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  request valid
- in_ready  out  1  block can accept a request
- fun  in  1  decode bit; 1 forces passthrough
- op  in  4  opcode; shifting only when 4'b1101
- shift_type  in  2  00 SLL, 01 SRL, 10 SRA, 11 ROR
- shift_amount  in  AMT_W  shift distance, 0..WIDTH-1
- rd2  in  WIDTH  operand to shift
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts the result
- data  out  WIDTH  result
- busy  out  1  high in any state other than IDLE

Behaviour:
- One clock domain. Synchronous, active-high reset.
- Reset values:
  - State = IDLE, in_ready = 1, out_valid = 0, busy = 0.
  - data = 0, internal accumulator = 0, remaining count = 0.
- The FSM has three states: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready = 1.
  - An accept happens in a cycle where in_valid = 1. On that edge, register rd2 into the accumulator, and register shift_amount (as the remaining count) and shift_type.
  - Passthrough case: op ≠ 4'b1101, or fun = 1, or shift_amount = 0. Go straight to DONE with accumulator = rd2.
  - Otherwise go to SHIFT.
- SHIFT:
  - in_ready = 0.
  - Each cycle: k = min(STEP, remaining). Shift the accumulator by k according to the registered type, then remaining -= k.
  - When remaining reaches 0 on this edge, go to DONE.
- Shift rules per step:
  - SLL and SRL fill with zeros.
  - SRA fills with the accumulator's MSB, so the sign is preserved across steps.
  - ROR moves bits shifted out of the LSB back into the MSB.
- Latency: accept in cycle t, n = ceil(shift_amount/STEP).
  - Shift: out_valid is first high in cycle t+1+n.
  - Passthrough: out_valid is first high in cycle t+1.
- DONE:
  - out_valid = 1 and data = accumulator.
  - data must stay stable while out_valid = 1 and out_ready = 0.
  - On out_valid && out_ready, go to IDLE; out_valid falls the next cycle.
  - No new request is accepted in the same cycle as the output handshake, so the minimum issue interval is 2 cycles.
- data keeps the last result after leaving DONE, until the next DONE.
- Input signals are ignored while in_ready = 0. Values in the accept cycle are the only ones sampled.
- in_ready, out_valid and busy are functions of state only; no combinational path from in_valid or out_ready.
- Reset in SHIFT or DONE aborts the operation: the next cycle is IDLE with out_valid = 0. The result is discarded.
- Reset has priority over every other event on the same edge.

Test Plan:
- Basic SLL: WIDTH = 32, STEP = 1, op = 1101, fun = 0, type 00, amount 4, rd2 = 0x0000_00F1, out_ready = 1.
  - Expect data = 0x0000_0F10 with out_valid high 5 cycles after the accept cycle.
  - Expect in_ready = 0 throughout.
- SRA and ROR with STEP = 4:
  - rd2 = 0x8000_0010, type 10, amount 5 → 0xFC00_0000 after ceil(5/4) = 2 SHIFT cycles.
  - rd2 = 0x0000_0013, type 11, amount 4 → 0x3000_0001.
- Passthrough:
  - op = 0100, rd2 = 0xDEAD_BEEF → 0xDEAD_BEEF in cycle t+1.
  - Repeat with op = 1101, fun = 1, and with amount 0; all must pass through in one cycle.
- Backpressure: hold out_ready = 0 for 6 cycles after out_valid rises.
  - data stays constant, in_ready stays 0, and a new in_valid is ignored.
  - Release out_ready; IDLE follows one cycle later and the next request is accepted.
- Reset mid-operation: assert rst during cycle 3 of an SRL by 20 (STEP = 1).
  - Next cycle: out_valid = 0, in_ready = 1, busy = 0, data = 0.
  - A subsequent SRL by 1 of 0x2 yields 0x1.
- Full range: amount 31 SLL of 0x1 yields 0x8000_0000.
  - Checked for STEP = 1 (31 cycles) and STEP = 16 (2 cycles).
